// File: rtl/jt51_wrq_if.sv
// Host write port of jt51_wrq: the CPU pushes register writes, the queue reports its fill state.
// Handshake: wr_en is a one-clk strobe carrying wr_addr/wr_din; the write is taken on that edge
// when full is low, otherwise it is dropped and ovf latches high until reset.
interface jt51_wrq_if;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_din;
  logic       full;
  logic       empty;
  logic       ovf;

  modport master (output wr_en, wr_addr, wr_din, input full, empty, ovf);
  modport slave  (input wr_en, wr_addr, wr_din, output full, empty, ovf);
endinterface

// File: rtl/jt51_wrq.sv
// Host write scheduler: FIFO of register writes, each decoded to one up_* strobe held for a full
// 32-slot sweep, or sent out on the global port. Define JT51_WRQ_SYNC_EN to align sweeps to slot 0.
module jt51_wrq #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       zero,
  jt51_wrq_if.slave  host,
  output logic       busy,
  output logic [7:0] din,
  output logic [1:0] op,
  output logic [2:0] ch,
  output logic       up_rl,
  output logic       up_kc,
  output logic       up_kf,
  output logic       up_pms,
  output logic       up_dt1,
  output logic       up_tl,
  output logic       up_ks,
  output logic       up_amsen,
  output logic       up_dt2,
  output logic       up_d1l,
  output logic       up_keyon,
  output logic       glb_we,
  output logic [7:0] glb_addr,
  output logic [7:0] glb_din,
  output logic [1:0] dbg_state
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_GLB, ST_SYNC, ST_HOLD} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fill;
  logic        full_q, full_d, empty_q, empty_d, ovf_q, ovf_d, busy_q, busy_d;
  logic [7:0]  din_q, din_d, glb_addr_q, glb_addr_d, glb_din_q, glb_din_d;
  logic [1:0]  op_q, op_d;
  logic [2:0]  ch_q, ch_d;
  logic [10:0] sel_q, sel_d, up_q, up_d;
  logic        glb_we_q, glb_we_d;
  logic [15:0] mem_q [DEPTH];

  logic        push, pop;
  logic [7:0]  h_addr, h_data;
  logic        dec_glb;
  logic [10:0] dec_sel;
  logic [1:0]  dec_op;
  logic [2:0]  dec_ch;

  assign push = host.wr_en && !full_q;
  assign {h_addr, h_data} = mem_q[rd_ptr_q[AW-1:0]];

  // Strobe bit order: rl kc kf pms dt1 tl ks amsen dt2 d1l keyon (bit 0 .. bit 10).
  always_comb begin
    dec_glb = 1'b0;
    dec_sel = '0;
    dec_op  = '0;
    dec_ch  = '0;
    if (h_addr == 8'h08) begin
      dec_sel = 11'h400;
    end else if (h_addr[7:5] == 3'd0) begin
      dec_glb = 1'b1;
    end else if (h_addr[7:5] == 3'd1) begin
      dec_sel = 11'(11'h001 << h_addr[4:3]);
      dec_ch  = h_addr[2:0];
    end else begin
      dec_sel = 11'(11'h010 << (h_addr[7:5] - 3'd2));
      dec_op  = h_addr[4:3];
      dec_ch  = h_addr[2:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    din_d      = din_q;
    op_d       = op_q;
    ch_d       = ch_q;
    sel_d      = sel_q;
    up_d       = up_q;
    glb_we_d   = 1'b0;
    glb_addr_d = glb_addr_q;
    glb_din_d  = glb_din_q;
    pop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_q) begin
          pop   = 1'b1;
          din_d = h_data;
          op_d  = dec_op;
          ch_d  = dec_ch;
          sel_d = dec_sel;
          if (dec_glb) begin
            state_d    = ST_GLB;
            glb_we_d   = 1'b1;
            glb_addr_d = h_addr;
            glb_din_d  = h_data;
          end else begin
`ifdef JT51_WRQ_SYNC_EN
            state_d = ST_SYNC;
`else
            state_d = ST_HOLD;
            cnt_d   = '0;
            up_d    = dec_sel;
`endif
          end
        end
      end
      ST_GLB: state_d = ST_IDLE;
      ST_SYNC: begin
        if (cen && zero) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          up_d    = sel_q;
        end
      end
      ST_HOLD: begin
        // The edge that consumes the 32nd cen ends the sweep and drops the strobe.
        if (cen) begin
          if (cnt_q == 5'd31) begin
            state_d = ST_IDLE;
            up_d    = '0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    fill     = wr_ptr_d - rd_ptr_d;
    full_d   = (fill == (AW+1)'(DEPTH));
    empty_d  = (wr_ptr_d == rd_ptr_d);
    ovf_d    = ovf_q | (host.wr_en & full_q);
    busy_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      din_q      <= '0;
      op_q       <= '0;
      ch_q       <= '0;
      sel_q      <= '0;
      up_q       <= '0;
      glb_we_q   <= 1'b0;
      glb_addr_q <= '0;
      glb_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      din_q      <= din_d;
      op_q       <= op_d;
      ch_q       <= ch_d;
      sel_q      <= sel_d;
      up_q       <= up_d;
      glb_we_q   <= glb_we_d;
      glb_addr_q <= glb_addr_d;
      glb_din_q  <= glb_din_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {host.wr_addr, host.wr_din};
  end

  assign host.full  = full_q;
  assign host.empty = empty_q;
  assign host.ovf   = ovf_q;
  assign busy       = busy_q;
  assign din        = din_q;
  assign op         = op_q;
  assign ch         = ch_q;
  assign glb_we     = glb_we_q;
  assign glb_addr   = glb_addr_q;
  assign glb_din    = glb_din_q;
  assign dbg_state  = state_q;
  assign {up_keyon, up_d1l, up_dt2, up_amsen, up_ks, up_tl,
          up_dt1, up_pms, up_kf, up_kc, up_rl} = up_q;
endmodule

// File: tb/tb_jt51_wrq.sv
// Bench for jt51_wrq: queue/sweep reference model, expected-response scoreboard, directed cases
// from the register-write scenarios followed by randomized writes under varying cen rates.
module tb_jt51_wrq;
  localparam int DEPTH = 4;
  localparam int W     = 32;
`ifdef JT51_WRQ_SYNC_EN
  localparam bit SYNC_EN = 1'b1;
`else
  localparam bit SYNC_EN = 1'b0;
`endif
  localparam int M_IDLE = 0, M_GLB = 1, M_SYNC = 2, M_HOLD = 3;

  logic       clk, rst, cen, zero;
  logic       busy, glb_we;
  logic [7:0] din, glb_addr, glb_din;
  logic [1:0] op, dbg_state;
  logic [2:0] ch;
  logic       up_rl, up_kc, up_kf, up_pms, up_dt1, up_tl, up_ks, up_amsen, up_dt2, up_d1l, up_keyon;
  logic [10:0] up_vec;

  jt51_wrq_if host();

  jt51_wrq #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cen(cen), .zero(zero), .host(host),
    .busy(busy), .din(din), .op(op), .ch(ch),
    .up_rl(up_rl), .up_kc(up_kc), .up_kf(up_kf), .up_pms(up_pms), .up_dt1(up_dt1),
    .up_tl(up_tl), .up_ks(up_ks), .up_amsen(up_amsen), .up_dt2(up_dt2), .up_d1l(up_d1l),
    .up_keyon(up_keyon), .glb_we(glb_we), .glb_addr(glb_addr), .glb_din(glb_din),
    .dbg_state(dbg_state)
  );

  assign up_vec = {up_keyon, up_d1l, up_dt2, up_amsen, up_ks, up_tl,
                   up_dt1, up_pms, up_kf, up_kc, up_rl};

  // Scoreboard and reference model state
  logic [W-1:0] exp_q[$];
  logic [15:0]  m_q[$];
  int           m_st, m_cens;
  logic         m_ovf;
  logic [3:0]   m_sel;
  logic [7:0]   m_din, m_gaddr, m_gdin;
  logic [1:0]   m_op;
  logic [2:0]   m_ch;
  bit           chk_en;
  int           n_cmp, n_fail;
  int           cen_mode, slot;

  // {strobe index (15 = global), op, ch}, from the address map ranges.
  function automatic logic [8:0] ref_decode(input logic [7:0] a);
    int v, idx, o, c;
    v = int'(a);
    if (v == 8) begin idx = 10; o = 0; c = 0; end
    else if (v < 32) begin idx = 15; o = 0; c = 0; end
    else if (v < 64) begin idx = (v - 32) / 8; o = 0; c = v % 8; end
    else begin idx = 4 + (v - 64) / 32; o = (v % 32) / 8; c = v % 8; end
    return {4'(idx), 2'(o), 3'(c)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Slot source: counts slots on cen, zero marks slot 0
  initial begin
    cen = 1'b0; zero = 1'b0; slot = 0;
    forever begin
      @(posedge clk);
      if (cen) slot = (slot + 1) % 32;
      #1;
      case (cen_mode)
        0:       cen = 1'b1;
        1:       cen = !cen;
        default: cen = ($urandom_range(0, 1) == 1);
      endcase
      zero = (slot == 0);
    end
  end

  // Reference model: advances once per clock edge on the inputs seen at that edge
  initial begin
    logic [15:0] e;
    logic [8:0]  dec;
    int          sz;
    bit          accept;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_q.delete(); exp_q.delete();
        m_st = M_IDLE; m_cens = 0; m_ovf = 0; m_sel = 0;
        m_din = 0; m_op = 0; m_ch = 0; m_gaddr = 0; m_gdin = 0;
        chk_en = 1'b1;
      end else begin
        sz = m_q.size();
        accept = host.wr_en && (sz < DEPTH);
        if (host.wr_en && !accept) m_ovf = 1'b1;
        case (m_st)
          M_IDLE: if (sz > 0) begin
            e = m_q.pop_front();
            dec = ref_decode(e[15:8]);
            m_din = e[7:0]; m_op = dec[4:3]; m_ch = dec[2:0];
            if (dec[8:5] == 4'd15) begin
              m_st = M_GLB; m_gaddr = e[15:8]; m_gdin = e[7:0];
            end else begin
              m_sel = dec[8:5];
              m_cens = 0;
              m_st = SYNC_EN ? M_SYNC : M_HOLD;
            end
          end
          M_GLB: m_st = M_IDLE;
          M_SYNC: if (cen && zero) begin m_st = M_HOLD; m_cens = 0; end
          default: if (cen) begin
            m_cens++;
            if (m_cens == 32) m_st = M_IDLE;
          end
        endcase
        if (accept) begin
          m_q.push_back({host.wr_addr, host.wr_din});
          exp_q.push_back({ref_decode(host.wr_addr), 7'd0, host.wr_addr, host.wr_din});
        end
      end
    end
  end

  // Monitor: per-cycle output check plus scoreboard pops on each applied entry
  initial begin
    bit          in_win;
    int          win_cens;
    logic [W-1:0] e;
    logic [10:0] exp_up;
    in_win = 0; win_cens = 0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        exp_up = (m_st == M_HOLD) ? 11'(11'd1 << m_sel) : 11'd0;
        check("up_strobes", 32'(up_vec), 32'(exp_up));
        check("glb_we", 32'(glb_we), 32'(m_st == M_GLB));
        check("busy", 32'(busy), 32'(m_st != M_IDLE));
        check("full", 32'(host.full), 32'(m_q.size() == DEPTH));
        check("empty", 32'(host.empty), 32'(m_q.size() == 0));
        check("ovf", 32'(host.ovf), 32'(m_ovf));
        check("din", 32'(din), 32'(m_din));
        check("op", 32'(op), 32'(m_op));
        check("ch", 32'(ch), 32'(m_ch));
        check("glb_addr", 32'(glb_addr), 32'(m_gaddr));
        check("glb_din", 32'(glb_din), 32'(m_gdin));
      end
      if (rst) begin
        in_win = 0;
      end else begin
        if (in_win && up_vec == 11'd0) begin
          check("hold_cen_count", 32'(win_cens), 32'd32);
          in_win = 0;
        end
        if (!in_win && up_vec != 11'd0) begin
          in_win = 1; win_cens = 0;
          if (exp_q.size() == 0) check("exp_q_underflow", 32'd1, 32'd0);
          else begin
            e = exp_q.pop_front();
            check("sb_strobe", 32'(up_vec), 32'(11'(11'd1 << e[31:28])));
            check("sb_op", 32'(op), 32'(e[27:26]));
            check("sb_ch", 32'(ch), 32'(e[25:23]));
            check("sb_din", 32'(din), 32'(e[7:0]));
          end
        end
        if (in_win && cen) win_cens++;
        if (glb_we) begin
          if (exp_q.size() == 0) check("exp_q_underflow", 32'd1, 32'd0);
          else begin
            e = exp_q.pop_front();
            check("sb_glb_kind", 32'(e[31:28]), 32'd15);
            check("sb_glb_addr", 32'(glb_addr), 32'(e[15:8]));
            check("sb_glb_din", 32'(glb_din), 32'(e[7:0]));
            check("sb_glb_no_strobe", 32'(up_vec), 32'd0);
          end
        end
      end
    end
  end

  // Driver tasks: all driving happens 1 time unit after a rising edge
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive_write(input logic [7:0] a, input logic [7:0] d);
    host.wr_en = 1'b1; host.wr_addr = a; host.wr_din = d;
    @(posedge clk); #1;
    host.wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(m_st == M_IDLE && m_q.size() == 0) && n < 3000) begin @(posedge clk); #1; n++; end
    if (n >= 3000) check({name, "_timeout"}, 32'd1, 32'd0);
    idle(2);
  endtask

  task automatic check_reset(input string name);
    check({name, "_empty"}, 32'(host.empty), 32'd1);
    check({name, "_full"}, 32'(host.full), 32'd0);
    check({name, "_ovf"}, 32'(host.ovf), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_strobes"}, 32'(up_vec), 32'd0);
    check({name, "_glb_we"}, 32'(glb_we), 32'd0);
    check({name, "_din_op_ch"}, {19'd0, din, op, ch}, 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; cen_mode = 0;
    host.wr_en = 1'b0; host.wr_addr = '0; host.wr_din = '0;
    idle(3);
    check_reset("por");
    rst = 1'b0;

    drive_write(8'h28, 8'h4A); wait_idle("kc");
    drive_write(8'h6D, 8'h7F); wait_idle("tl");
    drive_write(8'h14, 8'h3A); wait_idle("glb");

    for (int i = 0; i < 6; i++) drive_write(8'(8'h28 + i), 8'(8'h10 + i));
    check("burst_full", 32'(host.full), 32'd1);
    check("burst_ovf", 32'(host.ovf), 32'd1);
    wait_idle("burst");

    drive_write(8'h45, 8'h11); drive_write(8'h50, 8'h22); drive_write(8'h51, 8'h33);
    n = 0;
    while (!(m_st == M_HOLD && m_cens == 10) && n < 500) begin @(posedge clk); #1; n++; end
    if (n >= 500) check("hold10_timeout", 32'd1, 32'd0);
    rst = 1'b1; idle(1);
    check_reset("hold_rst");
    rst = 1'b0;
    drive_write(8'h6D, 8'h7F); wait_idle("post_rst");

    cen_mode = 1;
    drive_write(8'h08, 8'h78); wait_idle("keyon_half");

    cen_mode = 2;
    for (int i = 0; i < 150; i++) begin
      drive_write(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) != 0) idle(int'($urandom_range(0, 50)));
    end
    wait_idle("random");
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/jt51_wrq.md
# jt51_wrq

Host write scheduler for the register block. It queues CPU register writes in a small FIFO and decodes each address into one `up_*` strobe plus `op`/`ch`. Each strobe is held across one full 32-slot sweep, so the slot-matched register block captures it exactly once. Global registers (address < 0x20, except 0x08) bypass the sweep and go out on a one-cycle global write port.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `cen`  in  1  slot clock enable (P1); the slot counter advances only on `cen`.
- `zero`  in  1  slot-0 marker from the register block, valid in `cen` cycles.
- `wr_en`  in  1  host write strobe, one `clk` per write.
- `wr_addr`  in  8  register address.
- `wr_din`  in  8  register data.
- `full`  out  1  FIFO holds `DEPTH` entries.
- `empty`  out  1  FIFO holds no entries.
- `ovf`  out  1  sticky: a write was dropped while `full`.
- `busy`  out  1  an entry is being applied (any state except IDLE).
- `din`  out  8  data of the entry being applied.
- `op`  out  2  operator index of the entry.
- `ch`  out  3  channel index of the entry.
- `up_rl`, `up_kc`, `up_kf`, `up_pms`, `up_dt1`, `up_tl`, `up_ks`, `up_amsen`, `up_dt2`, `up_d1l`, `up_keyon`  out  1 each  update strobes; one-hot or all zero.
- `glb_we`  out  1  global register write, one `clk`.
- `glb_addr`  out  8  global register address.
- `glb_din`  out  8  global register data.

## Operation
- **Reset values.** All outputs are 0, except `empty`=1. The FIFO pointers are cleared and the state is IDLE. Reset in any state takes effect at the next edge and drops strobes immediately.
- **FIFO push.** `wr_en && !full` pushes {`wr_addr`, `wr_din`}. `wr_en && full` drops the write and sets `ovf`, even if a pop happens on the same edge. Pointers are `log2(DEPTH)+1` bits and wrap naturally.
- **Address decode.**
  - 0x08 → `up_keyon`.
  - 0x20–27 → `up_rl`; 0x28–2F → `up_kc`; 0x30–37 → `up_kf`; 0x38–3F → `up_pms`. For these, `op`=0 and `ch`=addr[2:0].
  - 0x40/60/80/A0/C0/E0 blocks (32 entries each) → `up_dt1`/`up_tl`/`up_ks`/`up_amsen`/`up_dt2`/`up_d1l`. For these, `op`=addr[4:3] and `ch`=addr[2:0].
  - Every other address < 0x20 is global.
- **States.**
  - IDLE: if `!empty`, pop the head entry, latch `din`/`op`/`ch`/kind. Go to GLB if the entry is global; otherwise go to SYNC (macro on) or HOLD (macro off).
  - GLB: `glb_we`=1 with the latched `glb_addr`/`glb_din` for exactly one `clk`, then IDLE.
  - SYNC: strobes low. On `cen && zero`, go to HOLD and clear the 5-bit counter.
  - HOLD: the decoded strobe is high. Each `cen` increments the counter. `cen` with counter==31 returns to IDLE and drops the strobe at that edge.
- **Output stability.** `din`/`op`/`ch` stay stable from the pop edge until the next pop; only strobes and `glb_we` return to 0.
- **Push during apply.** Pushes are accepted in every state; entries are applied strictly in FIFO order.

## Timing
- Pop happens on the first edge where state is IDLE and `!empty`. A write into an empty FIFO while IDLE is popped one `clk` after the push edge.
- HOLD spans exactly 32 `cen` cycles, which covers every slot once. With `cen` always 1, that is 32 `clk`.
- SYNC latency is 1–32 `cen` cycles, depending on slot phase.
- `busy` rises at the pop edge and falls at the edge that re-enters IDLE. Back-to-back entries therefore show one IDLE `clk` between them.
- `full`/`empty` are registered and updated at push/pop edges.

## Configuration
- `JT51_WRQ_SYNC_EN` defined: the SYNC state is present, and HOLD always starts on the slot-0 boundary (deterministic alignment for compare against a reference model).
- Undefined: SYNC is removed and HOLD starts the `clk` after the pop edge. Behaviour is otherwise identical; lower latency.

## Test plan
- KC write: `wr_addr`=0x28, `wr_din`=0x4A, `cen`=1 → `up_kc`=1 for 32 `clk` after the next `zero`, with `op`=0, `ch`=0, `din`=0x4A. No other strobe asserts; `busy` falls afterwards.
- TL write: 0x6D/0x7F → `up_tl` is held for one sweep with `op`=1, `ch`=5, `din`=0x7F.
- Global write: 0x14/0x3A → `glb_we`=1 for one `clk` with `glb_addr`=0x14, `glb_din`=0x3A. No `up_*` strobe asserts and no sweep wait occurs.
- Overflow (`DEPTH`=4): 6 back-to-back writes (0x28–0x2D) with the FIFO empty → one write is popped immediately, 4 are queued, `full`=1, the 6th is dropped and `ovf`=1. Five sweeps follow, in order `ch`=0..4.
- Reset during HOLD at counter 10 → at the next edge all strobes are 0, `busy`=0, `empty`=1, `ovf`=0. The next write behaves as after power-up.
- `cen` at half rate: 0x08/0x78 → `up_keyon` stays high for 64 `clk` (32 `cen`).
